// File: rtl/mm_ternary_pkg.sv
// mm_ternary_pkg: shared types, default sizing and the accumulate helper for the tile scheduler.
// MM_TILE_SCHED_SAT_EN selects saturating accumulation; otherwise sums wrap.
package mm_ternary_pkg;
  typedef enum logic {IDLE, RUN} sched_state_t;
  localparam int MAX_SLICES_DEF = 16;
  localparam int OUT_DEPTH_DEF = 2;
  localparam int SLICE_CNT_W = $clog2(MAX_SLICES_DEF + 1);
  localparam int FIFO_PTR_W = OUT_DEPTH_DEF > 1 ? $clog2(OUT_DEPTH_DEF) : 1;
  // Result is already reduced to the w-bit range; callers keep the low w bits.
  function automatic logic signed [63:0] acc_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
    logic signed [63:0] s;
`ifdef MM_TILE_SCHED_SAT_EN
    logic signed [63:0] hi, lo;
    s = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return s > hi ? hi : s < lo ? lo : s;
`else
    s = a + b;
    return (s <<< (64 - w)) >>> (64 - w);
`endif
  endfunction
endpackage

// File: rtl/mm_ternary_res_fifo.sv
// mm_ternary_res_fifo: completed-tile FIFO; head is read straight from storage so it holds while not popped.
module mm_ternary_res_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  assign do_push = push && (count != CW'(DEPTH) || do_pop);
  assign valid = count != '0;
  assign head = mem[rp];
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= push_data;
        wp <= wp == PW'(DEPTH - 1) ? '0 : wp + PW'(1);
      end
      if (do_pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/mm_ternary_tile_sched.sv
// mm_ternary_tile_sched: issues K-slices to a ternary MM array, accumulates partial sums, queues tiles.
// Define MM_TILE_SCHED_SAT_EN for saturating accumulators (default build wraps).
module mm_ternary_tile_sched
  import mm_ternary_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM    = 8,
  parameter int COL_NUM    = 8,
  parameter int LENGTH     = 8,
  parameter int CORE_LAT   = 4,
  parameter int ACC_WIDTH  = 16,
  parameter int MAX_SLICES = MAX_SLICES_DEF,
  parameter int OUT_DEPTH  = OUT_DEPTH_DEF
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic                                    in_last,
  input  logic [DATA_WIDTH*ROW_NUM*LENGTH-1:0]    in_mat,
  input  logic [DATA_WIDTH*LENGTH*COL_NUM-1:0]    in_fil,
  output logic [DATA_WIDTH*ROW_NUM*LENGTH-1:0]    core_mat,
  output logic [DATA_WIDTH*LENGTH*COL_NUM-1:0]    core_fil,
  input  logic [DATA_WIDTH*ROW_NUM*COL_NUM-1:0]   core_res,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [ACC_WIDTH*ROW_NUM*COL_NUM-1:0]    out_res,
  output logic                                    err_overrun
);
  localparam int N = ROW_NUM * COL_NUM;
  localparam int OW = ACC_WIDTH * N;
  localparam int SW = $clog2(MAX_SLICES + 1);
  localparam int FCW = $clog2(OUT_DEPTH + 1);
  localparam int LW = $clog2(CORE_LAT + OUT_DEPTH + 1);
  sched_state_t state, state_nxt;
  logic [SW-1:0] cnt;
  logic [CORE_LAT-1:0] pv, pf, pl;
  logic [LW-1:0] lip;
  logic [FCW-1:0] fifo_count;
  logic [OW-1:0] acc, sum;
  logic accept, at_max, eff_last, push;
  assign at_max = cnt == SW'(MAX_SLICES - 1);
  assign eff_last = in_last || at_max;
  // A last slice needs a FIFO slot reserved against every tile still in flight.
  assign in_ready = !reset && !(eff_last && (LW'(fifo_count) + lip >= LW'(OUT_DEPTH)));
  assign accept = in_valid && in_ready;
  assign push = pv[CORE_LAT-1] && pl[CORE_LAT-1];
  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = eff_last ? IDLE : RUN;
  end
  always_comb begin
    sum = '0;
    for (int e = 0; e < N; e++)
      sum[e*ACC_WIDTH +: ACC_WIDTH] = pf[CORE_LAT-1]
        ? ACC_WIDTH'($signed(core_res[e*DATA_WIDTH +: DATA_WIDTH]))
        : ACC_WIDTH'(acc_add(64'($signed(acc[e*ACC_WIDTH +: ACC_WIDTH])),
                             64'($signed(core_res[e*DATA_WIDTH +: DATA_WIDTH])), ACC_WIDTH));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pv <= '0;
      pf <= '0;
      pl <= '0;
      lip <= '0;
      acc <= '0;
      core_mat <= '0;
      core_fil <= '0;
      err_overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      pv <= CORE_LAT'({pv, accept});
      pf <= CORE_LAT'({pf, state == IDLE});
      pl <= CORE_LAT'({pl, eff_last});
      lip <= lip + LW'(accept && eff_last) - LW'(push);
      if (accept) begin
        core_mat <= in_mat;
        core_fil <= in_fil;
        cnt <= eff_last ? '0 : cnt + SW'(1);
      end
      if (accept && at_max && !in_last) err_overrun <= 1'b1;
      if (pv[CORE_LAT-1]) acc <= sum;
    end
  end
  mm_ternary_res_fifo #(.WIDTH(OW), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .push_data(sum), .pop(out_ready),
    .head(out_res), .valid(out_valid), .count(fifo_count)
  );
endmodule

// File: tb/tb_mm_ternary_tile_sched.sv
// tb_mm_ternary_tile_sched: directed checks of the tile scheduler around a behavioural ternary array.
module tb_mm_ternary_tile_sched;
  import mm_ternary_pkg::*;
  localparam int DW = 8, R = 8, C = 8, L = 8, CORE_LAT = 4, AW = 8, MAXS = 16, DEPTH = 2;
  localparam int MW = DW * R * L;
  localparam int RW = DW * R * C;
  localparam int OW = AW * R * C;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, err_overrun;
  logic [MW-1:0] in_mat = '0, in_fil = '0, core_mat, core_fil;
  logic [RW-1:0] core_res;
  logic [OW-1:0] out_res;
  logic [RW-1:0] rp [CORE_LAT-1];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  mm_ternary_tile_sched #(.DATA_WIDTH(DW), .ROW_NUM(R), .COL_NUM(C), .LENGTH(L), .CORE_LAT(CORE_LAT),
    .ACC_WIDTH(AW), .MAX_SLICES(MAXS), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_mat(in_mat), .in_fil(in_fil), .core_mat(core_mat), .core_fil(core_fil), .core_res(core_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .err_overrun(err_overrun));
  function automatic logic [RW-1:0] mm(input logic [MW-1:0] m, input logic [MW-1:0] f);
    logic [RW-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) begin
        s = 0;
        for (int k = 0; k < L; k++)
          s += int'($signed(m[(i*L+k)*DW +: DW])) * int'($signed(f[(k*C+j)*DW +: DW]));
        r[(i*C+j)*DW +: DW] = s[DW-1:0];
      end
    return r;
  endfunction
  // Array stand-in: result of the registered operands appears CORE_LAT-1 register stages later.
  always @(posedge clk) begin
    rp[0] <= mm(core_mat, core_fil);
    for (int i = 1; i < CORE_LAT - 1; i++) rp[i] <= rp[i-1];
  end
  assign core_res = rp[CORE_LAT-2];
  function automatic logic [MW-1:0] fill(input logic signed [DW-1:0] v, input bit onehot);
    logic [MW-1:0] r;
    r = '0;
    for (int e = 0; e < R * L; e++) if (!onehot || e < C) r[e*DW +: DW] = v;
    return r;
  endfunction
  function automatic logic [OW-1:0] tile(input logic signed [AW-1:0] v);
    logic [OW-1:0] r;
    for (int e = 0; e < R * C; e++) r[e*AW +: AW] = v;
    return r;
  endfunction
  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic send(input string tag, input logic last, input logic [MW-1:0] m, input logic [MW-1:0] f);
    in_valid = 1'b1;
    in_last = last;
    in_mat = m;
    in_fil = f;
    for (int t = 0; t < 50 && !in_ready; t++) tick();
    check(tag, in_ready, 1);
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic wait_out(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check(tag, out_valid, 1);
  endtask
  task automatic pop;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
  initial begin
    int n;
    bit seen;
    @(negedge clk);
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err_overrun, 0);
    check("rst_out_res", out_res, 0);
    check("rst_core_mat", core_mat, 0);
    reset = 1'b0;
    tick();
    check("idle_in_ready", in_ready, 1);
    // Three +1/+1 slices: each slice contributes 8, tile = 24.
    send("t1_s0", 0, fill(1, 0), fill(1, 0));
    check("t1_state_run", dut.state, RUN);
    send("t1_s1", 0, fill(1, 0), fill(1, 0));
    send("t1_s2", 1, fill(1, 0), fill(1, 0));
    check("t1_core_fil", core_fil, fill(1, 0));
    wait_out("t1_valid", n);
    check("t1_latency", 3 + n, CORE_LAT + 3);
    check("t1_res", out_res, tile(24));
    pop();
    check("t1_popped", out_valid, 0);
    // One-slice tile of -1 filters.
    send("t2_s0", 1, fill(1, 0), fill(-1, 0));
    check("t2_state_idle", dut.state, IDLE);
    wait_out("t2_valid", n);
    check("t2_res", out_res, tile(-8));
    pop();
    // Back-pressure: third one-slice tile must wait for a FIFO slot.
    send("t3_a", 1, fill(1, 0), fill(1, 0));
    send("t3_b", 1, fill(1, 0), fill(-1, 0));
    in_valid = 1'b1;
    in_last = 1'b1;
    in_mat = fill(1, 0);
    in_fil = fill(1, 1);
    check("t3_stall_inflight", in_ready, 0);
    for (int t = 0; t < 8; t++) tick();
    check("t3_stall_full", in_ready, 0);
    check("t3_head_a", out_res, tile(8));
    pop();
    check("t3_ready_after_pop", in_ready, 1);
    check("t3_head_b", out_res, tile(-8));
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    check("t3_head_b_hold", out_res, tile(-8));
    pop();
    wait_out("t3_c_valid", n);
    check("t3_head_c", out_res, tile(1));
    pop();
    for (int t = 0; t < 6; t++) tick();
    check("t3_no_dup", out_valid, 0);
    // Overrun: 16 slices summing 1 each without in_last, then a fresh -8 tile.
    for (int s = 0; s < MAXS - 1; s++) send("t4_s", 0, fill(1, 0), fill(1, 1));
    check("t4_err_before", err_overrun, 0);
    send("t4_s15", 0, fill(1, 0), fill(1, 1));
    check("t4_err_set", err_overrun, 1);
    check("t4_forced_idle", dut.state, IDLE);
    send("t4_next", 1, fill(1, 0), fill(-1, 0));
    wait_out("t4_valid", n);
    check("t4_res", out_res, tile(16));
    pop();
    wait_out("t4_next_valid", n);
    check("t4_next_res", out_res, tile(-8));
    pop();
    // 16 slices of +8 reach 128, one past the 8-bit accumulator range.
    for (int s = 0; s < MAXS - 1; s++) send("t5_s", 0, fill(1, 0), fill(1, 0));
    send("t5_last", 1, fill(1, 0), fill(1, 0));
    wait_out("t5_valid", n);
`ifdef MM_TILE_SCHED_SAT_EN
    check("t5_sat", out_res, tile(127));
`else
    check("t5_wrap", out_res, tile(-128));
`endif
    check("t5_err_sticky", err_overrun, 1);
    pop();
    // Reset with two slices in flight discards the tile.
    send("t6_s0", 0, fill(1, 0), fill(1, 0));
    send("t6_s1", 0, fill(1, 0), fill(1, 0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_err_clr", err_overrun, 0);
    check("t6_state", dut.state, IDLE);
    check("t6_core_mat", core_mat, 0);
    seen = 1'b0;
    for (int t = 0; t < 10; t++) begin
      seen |= out_valid;
      tick();
    end
    check("t6_no_out", seen, 0);
    send("t6_n0", 0, fill(1, 0), fill(-1, 0));
    send("t6_n1", 1, fill(1, 0), fill(-1, 0));
    wait_out("t6_valid", n);
    check("t6_res", out_res, tile(-16));
    pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
